// File: rtl/freq_gate_counter.sv
`default_nettype none
// ============================================================================
// freq_gate_counter: counts sig_in rising edges during each gate-high window.
// Revision: 1.0
// ============================================================================
module freq_gate_counter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             gate_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] gate_sync;
  logic [SYNC_STAGES-1:0] sig_sync;
  logic                   gate_prev;
  logic                   sig_prev;
  logic [SYNC_STAGES:0]   fill;
  logic [CNT_W-1:0]       counter;
  logic                   ovf;

  logic gate_s;
  logic sig_s;
  logic gate_rise;
  logic gate_fall;
  logic sig_rise;
  logic primed;

  assign gate_s    = gate_sync[SYNC_STAGES-1];
  assign sig_s     = sig_sync[SYNC_STAGES-1];
  assign gate_rise = gate_s & ~gate_prev;
  assign gate_fall = ~gate_s & gate_prev;
  assign sig_rise  = sig_s & ~sig_prev;
  // The synchroniser powers up at 0; only trust its gate level once it has
  // been refilled from the pin, so a high gate at reset release is not armed.
  assign primed    = fill[SYNC_STAGES];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_sync <= '0;
      sig_sync  <= '0;
      gate_prev <= 1'b0;
      sig_prev  <= 1'b0;
      fill      <= '0;
    end else begin
      gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate_in};
      sig_sync  <= {sig_sync[SYNC_STAGES-2:0], sig_in};
      gate_prev <= gate_s;
      sig_prev  <= sig_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      ovf         <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        counter <= '0;
        ovf     <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (primed && !gate_s) state <= ARMED;
          end
          ARMED: begin
            if (gate_rise) begin
              counter <= CNT_W'(sig_rise);
              ovf     <= 1'b0;
              busy    <= 1'b1;
              state   <= COUNT;
            end
          end
          COUNT: begin
            // Gate fall closes the window; a coincident sig rise is outside it.
            if (gate_fall) begin
              count_out   <= counter;
              overflow    <= ovf;
              count_valid <= 1'b1;
              busy        <= 1'b0;
              state       <= ARMED;
            end else if (sig_rise) begin
              if (&counter) ovf <= 1'b1;
              else          counter <= counter + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_counter.sv
`default_nettype none
// Testbench for freq_gate_counter: sample-level waveforms checked against a
// window-counting reference model.
module tb_freq_gate_counter;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          gate_in = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          overflow;
  logic          busy;

  always #5 clk = ~clk;

  freq_gate_counter #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk_in(clk), .rst_n(rst_n), .en(en), .gate_in(gate_in), .sig_in(sig_in),
    .count_out(count_out), .count_valid(count_valid), .overflow(overflow), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit gw[$];
  bit sw[$];
  bit ew[$];
  int exp_cnt[$];
  bit exp_ovf[$];
  int exp_busy;
  int cap_cnt[$];
  bit cap_ovf[$];
  int busy_cyc  = 0;
  int dbl_valid = 0;
  bit last_valid = 1'b0;

  always @(negedge clk) begin
    if (count_valid === 1'b1) begin
      cap_cnt.push_back(int'(count_out));
      cap_ovf.push_back(overflow);
      if (last_valid) dbl_valid++;
    end
    last_valid = (count_valid === 1'b1);
    if (busy === 1'b1) busy_cyc++;
  end

  task automatic clear_wave();
    gw.delete(); sw.delete(); ew.delete();
  endtask

  task automatic add_gate(bit v, int n);
    repeat (n) begin gw.push_back(v); sw.push_back(1'b0); ew.push_back(1'b1); end
  endtask

  task automatic sig_burst(int start, int cnt, int period, int hi);
    for (int i = 0; i < cnt; i++)
      for (int h = 0; h < hi; h++)
        if (start + i*period + h < gw.size()) sw[start + i*period + h] = 1'b1;
  endtask

  task automatic sig_periodic(int period, int phase);
    for (int j = 0; j < gw.size(); j++)
      sw[j] = (((j + period - phase) % period) < period/2);
  endtask

  task automatic sig_random();
    int j = 0;
    bit v = 1'b0;
    while (j < gw.size()) begin
      int len = $urandom_range(2, 9);
      for (int h = 0; h < len && j < gw.size(); h++) begin sw[j] = v; j++; end
      v = ~v;
    end
  endtask

  // Leaves rst_n released at a falling edge; play() drives sample 0 at once.
  task automatic do_reset(bit g0);
    @(negedge clk);
    rst_n = 1'b0; gate_in = g0; sig_in = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap_cnt.delete(); cap_ovf.delete();
    busy_cyc = 0; dbl_valid = 0; last_valid = 1'b0;
  endtask

  task automatic play(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      if (i > lo) @(negedge clk);
      gate_in = gw[i]; sig_in = sw[i]; en = ew[i];
    end
  endtask

  task automatic flush();
    @(negedge clk);
    sig_in = 1'b0; en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // A window runs from a gate-rise sample to the next gate-fall sample; it is
  // measured only if a gate-low sample (after the first) preceded its rise.
  function automatic void run_model();
    bit armed = 1'b0;
    int k = -1;
    exp_cnt.delete(); exp_ovf.delete(); exp_busy = 0;
    for (int j = 0; j < gw.size(); j++) begin
      bit pg = (j > 0) ? gw[j-1] : 1'b0;
      if (!armed) begin
        if (j >= 1 && !gw[j]) armed = 1'b1;
      end else if (gw[j] && !pg) begin
        k = j;
      end else if (!gw[j] && pg && k >= 0) begin
        int raw = 0;
        for (int t = k; t < j; t++)
          if (sw[t] && !((t > 0) ? sw[t-1] : 1'b0)) raw++;
        exp_cnt.push_back((raw > MAXC) ? MAXC : raw);
        exp_ovf.push_back(raw > MAXC);
        exp_busy += j - k;
        k = -1;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; gate_in = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++; if (count_out !== '0) begin n_fail++; $display("FAIL reset_count_out: got %0d, expected 0", count_out); end
    n_assert++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_count_valid: got %b, expected 0", count_valid); end
    n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_assert++; if (busy !== 1'b0 || count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_en0: got busy=%b valid=%b, expected 0/0", busy, count_valid); end
  endtask

  task automatic test_basic();
    clear_wave();
    add_gate(1'b0, 20);
    repeat (3) begin add_gate(1'b1, 100); add_gate(1'b0, 100); end
    sig_periodic(10, 3);
    run_model();
    do_reset(1'b0); play(0, gw.size()); flush();
    n_assert++; if (cap_cnt.size() !== exp_cnt.size()) begin n_fail++; $display("FAIL basic_pulses: got %0d, expected %0d", cap_cnt.size(), exp_cnt.size()); end
    for (int i = 0; i < exp_cnt.size() && i < cap_cnt.size(); i++) begin
      n_assert++;
      if (cap_cnt[i] !== exp_cnt[i] || cap_ovf[i] !== exp_ovf[i]) begin
        n_fail++; $display("FAIL basic_win%0d: got count=%0d ovf=%b, expected count=%0d ovf=%b", i, cap_cnt[i], cap_ovf[i], exp_cnt[i], exp_ovf[i]);
      end
    end
    n_assert++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL basic_busy: got %0d cycles, expected %0d", busy_cyc, exp_busy); end
    n_assert++; if (dbl_valid !== 0) begin n_fail++; $display("FAIL basic_valid_width: got %0d back-to-back pulses, expected 0", dbl_valid); end
    n_assert++; if (int'(count_out) !== exp_cnt[exp_cnt.size()-1]) begin n_fail++; $display("FAIL basic_hold: got %0d, expected %0d", count_out, exp_cnt[exp_cnt.size()-1]); end
  endtask

  task automatic test_saturation();
    clear_wave();
    add_gate(1'b0, 20); add_gate(1'b1, 100); add_gate(1'b0, 60); add_gate(1'b1, 100); add_gate(1'b0, 60);
    sig_burst(22, 20, 4, 2);
    sig_burst(185, 5, 10, 5);
    run_model();
    do_reset(1'b0); play(0, gw.size()); flush();
    n_assert++; if (cap_cnt.size() !== exp_cnt.size()) begin n_fail++; $display("FAIL sat_pulses: got %0d, expected %0d", cap_cnt.size(), exp_cnt.size()); end
    for (int i = 0; i < exp_cnt.size() && i < cap_cnt.size(); i++) begin
      n_assert++;
      if (cap_cnt[i] !== exp_cnt[i] || cap_ovf[i] !== exp_ovf[i]) begin
        n_fail++; $display("FAIL sat_win%0d: got count=%0d ovf=%b, expected count=%0d ovf=%b", i, cap_cnt[i], cap_ovf[i], exp_cnt[i], exp_ovf[i]);
      end
    end
    n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_hold: got %b, expected 0", overflow); end
  endtask

  task automatic test_boundary();
    clear_wave();
    add_gate(1'b0, 20); add_gate(1'b1, 100); add_gate(1'b0, 60);
    sig_burst(20, 6, 20, 5);
    run_model();
    do_reset(1'b0); play(0, gw.size()); flush();
    n_assert++; if (cap_cnt.size() !== 1) begin n_fail++; $display("FAIL bound_pulses: got %0d, expected 1", cap_cnt.size()); end
    n_assert++;
    if (cap_cnt.size() < 1 || cap_cnt[0] !== exp_cnt[0]) begin
      n_fail++; $display("FAIL bound_count: got %0d, expected %0d", (cap_cnt.size() > 0) ? cap_cnt[0] : -1, exp_cnt[0]);
    end
  endtask

  task automatic test_startup();
    clear_wave();
    add_gate(1'b1, 60); add_gate(1'b0, 100); add_gate(1'b1, 100); add_gate(1'b0, 100);
    sig_burst(3, 7, 8, 4);
    sig_burst(163, 10, 10, 5);
    run_model();
    do_reset(1'b1); play(0, gw.size()); flush();
    n_assert++; if (cap_cnt.size() !== exp_cnt.size()) begin n_fail++; $display("FAIL start_pulses: got %0d, expected %0d", cap_cnt.size(), exp_cnt.size()); end
    for (int i = 0; i < exp_cnt.size() && i < cap_cnt.size(); i++) begin
      n_assert++;
      if (cap_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL start_win%0d: got %0d, expected %0d", i, cap_cnt[i], exp_cnt[i]); end
    end
  endtask

  task automatic test_abort();
    clear_wave();
    add_gate(1'b0, 20);
    repeat (3) begin add_gate(1'b1, 100); add_gate(1'b0, 100); end
    sig_periodic(10, 3);
    ew[280] = 1'b0;
    do_reset(1'b0); play(0, 300);
    n_assert++; if (cap_cnt.size() !== 1 || int'(count_out) !== 10) begin n_fail++; $display("FAIL abort_hold: got %0d pulses count_out=%0d, expected 1 pulse count_out=10", cap_cnt.size(), count_out); end
    play(300, gw.size()); flush();
    n_assert++; if (cap_cnt.size() !== 2) begin n_fail++; $display("FAIL abort_pulses: got %0d, expected 2", cap_cnt.size()); end
    n_assert++; if (cap_cnt.size() >= 2 && cap_cnt[1] !== 10) begin n_fail++; $display("FAIL abort_resume: got %0d, expected 10", cap_cnt[1]); end
  endtask

  task automatic test_async_reset();
    clear_wave();
    add_gate(1'b0, 20);
    repeat (2) begin add_gate(1'b1, 100); add_gate(1'b0, 100); end
    sig_periodic(10, 3);
    do_reset(1'b0); play(0, 260);
    n_assert++; if (busy !== 1'b1 || int'(count_out) !== 10) begin n_fail++; $display("FAIL async_pre: got busy=%b count_out=%0d, expected 1/10", busy, count_out); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (count_out !== '0 || busy !== 1'b0 || overflow !== 1'b0 || count_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_clear: got count=%0d busy=%b ovf=%b valid=%b, expected all 0", count_out, busy, overflow, count_valid);
    end
    clear_wave();
    add_gate(1'b1, 40); add_gate(1'b0, 100); add_gate(1'b1, 100); add_gate(1'b0, 100);
    sig_burst(3, 4, 8, 4);
    sig_burst(143, 10, 10, 5);
    run_model();
    do_reset(1'b1); play(0, gw.size()); flush();
    n_assert++; if (cap_cnt.size() !== 1) begin n_fail++; $display("FAIL async_pulses: got %0d, expected 1", cap_cnt.size()); end
    n_assert++; if (cap_cnt.size() >= 1 && cap_cnt[0] !== exp_cnt[0]) begin n_fail++; $display("FAIL async_count: got %0d, expected %0d", cap_cnt[0], exp_cnt[0]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int nwin = $urandom_range(4, 6);
      clear_wave();
      add_gate(1'b0, $urandom_range(10, 40));
      repeat (nwin) begin add_gate(1'b1, $urandom_range(20, 90)); add_gate(1'b0, $urandom_range(10, 60)); end
      sig_random();
      run_model();
      do_reset(1'b0); play(0, gw.size()); flush();
      n_assert++; if (cap_cnt.size() !== exp_cnt.size()) begin n_fail++; $display("FAIL rand%0d_pulses: got %0d, expected %0d", it, cap_cnt.size(), exp_cnt.size()); end
      for (int i = 0; i < exp_cnt.size() && i < cap_cnt.size(); i++) begin
        n_assert++;
        if (cap_cnt[i] !== exp_cnt[i] || cap_ovf[i] !== exp_ovf[i]) begin
          n_fail++; $display("FAIL rand%0d_win%0d: got count=%0d ovf=%b, expected count=%0d ovf=%b", it, i, cap_cnt[i], cap_ovf[i], exp_cnt[i], exp_ovf[i]);
        end
      end
      n_assert++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL rand%0d_busy: got %0d, expected %0d", it, busy_cyc, exp_busy); end
      n_assert++; if (dbl_valid !== 0) begin n_fail++; $display("FAIL rand%0d_valid_width: got %0d, expected 0", it, dbl_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_boundary();
    test_startup();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
